// File: rtl/adc_capture_core.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : adc_capture_core                                              |
// | Purpose  : Ring-buffer ADC capture with level-crossing trigger and       |
// |            pre/post-trigger window readout over AXI4-Stream.             |
// | Options  : ADC_CAPTURE_SWTRIG_EN adds ctrl_swtrig (forced trigger on the |
// |            next accepted sample while ARMED).                            |
// | Ports    : ACLK/ARESETN        clock, async active-low reset             |
// |            adc_valid/adc_data  sample input (two's complement)           |
// |            ctrl_arm/ctrl_abort control pulses                            |
// |            cfg_*               threshold, edge, pre count P, post count Q|
// |            m_axis_*            32-bit sign-extended sample stream        |
// |            sts_*               busy, done pulse, trigger counter         |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module adc_capture_core #(
  parameter int DEPTH_LOG2 = 10,
  parameter int SAMPLE_W   = 16
) (
  input  logic                  ACLK,
  input  logic                  ARESETN,
  input  logic                  adc_valid,
  input  logic [SAMPLE_W-1:0]   adc_data,
  input  logic                  ctrl_arm,
  input  logic                  ctrl_abort,
`ifdef ADC_CAPTURE_SWTRIG_EN
  input  logic                  ctrl_swtrig,
`endif
  input  logic [SAMPLE_W-1:0]   cfg_threshold,
  input  logic                  cfg_edge,
  input  logic [DEPTH_LOG2-1:0] cfg_pre,
  input  logic [DEPTH_LOG2-1:0] cfg_post,
  output logic [31:0]           m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic                  sts_busy,
  output logic                  sts_done,
  output logic [31:0]           sts_trig_count
);

  localparam int                  c_N   = 1 << DEPTH_LOG2;
  localparam int                  c_EXT = 32 - SAMPLE_W;
  localparam logic [DEPTH_LOG2:0] c_NM1 = (DEPTH_LOG2+1)'(c_N - 1);
  localparam logic [DEPTH_LOG2-1:0] c_ONE = DEPTH_LOG2'(1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FILL  = 3'd1,
    S_ARMED = 3'd2,
    S_POST  = 3'd3,
    S_DRAIN = 3'd4
  } state_t;

  state_t r_state, w_next;

  logic [SAMPLE_W-1:0]   r_mem [0:c_N-1];
  logic [SAMPLE_W-1:0]   r_ram_q;

  logic [DEPTH_LOG2-1:0] r_pre, r_post, r_fill_cnt, r_post_cnt;
  logic [DEPTH_LOG2-1:0] r_wr_ptr, r_rd_addr, r_iss_cnt;
  logic [SAMPLE_W-1:0]   r_thr, r_prev;
  logic                  r_edge, r_prev_vld, r_rd_more, r_done;
  logic [31:0]           r_trig_count;

  // Read pipeline: one RAM read in flight, an output register and a skid slot.
  logic                  r_inflight, r_infl_last;
  logic                  r_tvalid, r_tlast, r_sk_vld, r_sk_last;
  logic [31:0]           r_tdata, r_sk_data;

  logic [DEPTH_LOG2:0]   w_pq, w_post_room;
  logic [DEPTH_LOG2-1:0] w_post_sat, w_len_m1;
  logic                  w_arm_ok, w_we, w_lvl, w_sw, w_trig, w_trig_ok;
  logic                  w_hs, w_done, w_issue, w_iss_last;
  logic [1:0]            w_occ;
  logic [31:0]           w_arr;

  // Q is clipped so the window never exceeds the ring depth.
  assign w_pq        = {1'b0, cfg_pre} + {1'b0, cfg_post};
  assign w_post_room = c_NM1 - {1'b0, cfg_pre};
  assign w_post_sat  = (w_pq > c_NM1) ? w_post_room[DEPTH_LOG2-1:0] : cfg_post;
  assign w_len_m1    = r_pre + r_post;

  assign w_arm_ok  = (r_state == S_IDLE) && ctrl_arm && !ctrl_abort;
  assign w_we      = adc_valid && !ctrl_abort &&
                     ((r_state == S_FILL) || (r_state == S_ARMED) || (r_state == S_POST));
  assign w_lvl     = r_prev_vld &&
                     (r_edge ? (($signed(r_prev) >= $signed(r_thr)) && ($signed(adc_data) <  $signed(r_thr)))
                             : (($signed(r_prev) <  $signed(r_thr)) && ($signed(adc_data) >= $signed(r_thr))));
  assign w_trig    = (r_state == S_ARMED) && adc_valid && (w_lvl || w_sw);
  assign w_trig_ok = w_trig && !ctrl_abort;

  assign w_hs   = r_tvalid && m_axis_tready;
  assign w_done = (r_state == S_DRAIN) && w_hs && r_tlast && !ctrl_abort;
  assign w_arr  = {{c_EXT{r_ram_q[SAMPLE_W-1]}}, r_ram_q};

  // Issue a read only if the result is guaranteed a slot when it lands:
  // items held after this edge plus the new one must fit out-reg + skid.
  assign w_occ      = {1'b0, r_tvalid} + {1'b0, r_sk_vld} + {1'b0, r_inflight} - {1'b0, w_hs};
  assign w_iss_last = (r_iss_cnt == w_len_m1);
  assign w_issue    = (r_state == S_DRAIN) && !ctrl_abort && r_rd_more && (w_occ < 2'd2);

`ifdef ADC_CAPTURE_SWTRIG_EN
  logic r_sw_pend;
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_sw_pend <= 1'b0;
    end else if ((r_state != S_ARMED) || ctrl_abort) begin
      r_sw_pend <= 1'b0;
    end else if (ctrl_swtrig) begin
      r_sw_pend <= 1'b1;
    end
  end
  assign w_sw = r_sw_pend || ctrl_swtrig;
`else
  assign w_sw = 1'b0;
`endif

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (ctrl_arm) w_next = (cfg_pre == '0) ? S_ARMED : S_FILL;
      S_FILL:  if (adc_valid && (r_fill_cnt == r_pre - c_ONE)) w_next = S_ARMED;
      S_ARMED: if (w_trig) w_next = (r_post == '0) ? S_DRAIN : S_POST;
      S_POST:  if (adc_valid && (r_post_cnt == r_post - c_ONE)) w_next = S_DRAIN;
      S_DRAIN: if (w_hs && r_tlast) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
    if (ctrl_abort) w_next = S_IDLE;
  end

  // Buffer: single synchronous-read RAM, no reset.
  always_ff @(posedge ACLK) begin
    if (w_we) r_mem[r_wr_ptr] <= adc_data;
    r_ram_q <= r_mem[r_rd_addr];
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_state      <= S_IDLE;
      r_done       <= 1'b0;
      r_trig_count <= '0;
      r_pre        <= '0;
      r_post       <= '0;
      r_thr        <= '0;
      r_edge       <= 1'b0;
      r_wr_ptr     <= '0;
      r_fill_cnt   <= '0;
      r_post_cnt   <= '0;
      r_prev       <= '0;
      r_prev_vld   <= 1'b0;
      r_rd_addr    <= '0;
      r_iss_cnt    <= '0;
      r_rd_more    <= 1'b0;
      r_inflight   <= 1'b0;
      r_infl_last  <= 1'b0;
      r_tvalid     <= 1'b0;
      r_tlast      <= 1'b0;
      r_tdata      <= '0;
      r_sk_vld     <= 1'b0;
      r_sk_last    <= 1'b0;
      r_sk_data    <= '0;
    end else begin
      r_state <= w_next;
      r_done  <= w_done;
      if (w_trig_ok) r_trig_count <= r_trig_count + 32'd1;

      if (w_arm_ok) begin
        r_pre      <= cfg_pre;
        r_post     <= w_post_sat;
        r_thr      <= cfg_threshold;
        r_edge     <= cfg_edge;
        r_wr_ptr   <= '0;
        r_fill_cnt <= '0;
        r_post_cnt <= '0;
        r_prev_vld <= 1'b0;
      end

      if (w_we) begin
        r_wr_ptr   <= r_wr_ptr + c_ONE;
        r_prev     <= adc_data;
        r_prev_vld <= 1'b1;
        if (r_state == S_FILL) r_fill_cnt <= r_fill_cnt + c_ONE;
        if (r_state == S_POST) r_post_cnt <= r_post_cnt + c_ONE;
      end

      // The trigger sample lands at r_wr_ptr; the window starts P before it.
      if (w_trig_ok) begin
        r_rd_addr <= r_wr_ptr - r_pre;
        r_iss_cnt <= '0;
        r_rd_more <= 1'b1;
      end

      if ((r_state != S_DRAIN) || ctrl_abort) begin
        r_inflight  <= 1'b0;
        r_infl_last <= 1'b0;
        r_tvalid    <= 1'b0;
        r_tlast     <= 1'b0;
        r_sk_vld    <= 1'b0;
      end else begin
        r_inflight  <= w_issue;
        r_infl_last <= w_issue && w_iss_last;
        if (w_issue) begin
          r_rd_addr <= r_rd_addr + c_ONE;
          r_iss_cnt <= r_iss_cnt + c_ONE;
          if (w_iss_last) r_rd_more <= 1'b0;
        end
        if (!r_tvalid || w_hs) begin
          if (r_sk_vld) begin
            r_tdata   <= r_sk_data;
            r_tlast   <= r_sk_last;
            r_tvalid  <= 1'b1;
            r_sk_vld  <= r_inflight;
            r_sk_data <= w_arr;
            r_sk_last <= r_infl_last;
          end else if (r_inflight) begin
            r_tdata  <= w_arr;
            r_tlast  <= r_infl_last;
            r_tvalid <= 1'b1;
          end else begin
            r_tvalid <= 1'b0;
            r_tlast  <= 1'b0;
          end
        end else if (r_inflight) begin
          r_sk_vld  <= 1'b1;
          r_sk_data <= w_arr;
          r_sk_last <= r_infl_last;
        end
      end
    end
  end

  assign m_axis_tdata   = r_tdata;
  assign m_axis_tvalid  = r_tvalid;
  assign m_axis_tlast   = r_tlast;
  assign sts_busy       = (r_state != S_IDLE);
  assign sts_done       = r_done;
  assign sts_trig_count = r_trig_count;

endmodule
`default_nettype wire

// File: doc/adc_capture_core.md
# adc_capture_core

Sample-capture engine driven by the `adc_triggered_dataq_unit` AXI4-Lite register slave. It continuously records ADC samples into a ring buffer, detects a level-crossing trigger, and captures a configured pre/post-trigger window. It then streams the window over AXI4-Stream to the downstream DMA. Configuration and control come from the register slave; status goes back to it.

## Interface
Parameters:
- `DEPTH_LOG2`, 10: ring buffer depth N = 2^DEPTH_LOG2 samples.
- `SAMPLE_W`, 16: ADC sample width, two's complement.

Ports:
- `ACLK` in 1: single clock for all logic.
- `ARESETN` in 1: asynchronous active-low reset.
- `adc_valid` in 1: sample strobe; a sample is accepted only when high.
- `adc_data` in SAMPLE_W: signed sample.
- `ctrl_arm` in 1: one-cycle pulse; starts a capture from IDLE.
- `ctrl_abort` in 1: one-cycle pulse; returns to IDLE from any state.
- `cfg_threshold` in SAMPLE_W: signed trigger level.
- `cfg_edge` in 1: 0 = rising, 1 = falling.
- `cfg_pre` in DEPTH_LOG2: pre-trigger sample count P.
- `cfg_post` in DEPTH_LOG2: post-trigger sample count Q.
- `m_axis_tdata` out 32: sample sign-extended to 32 bits.
- `m_axis_tvalid` out 1, `m_axis_tready` in 1, `m_axis_tlast` out 1: AXI4-Stream master.
- `sts_busy` out 1: high when state is not IDLE.
- `sts_done` out 1: one-cycle pulse when a capture completes.
- `sts_trig_count` out 32: count of accepted triggers; wraps at 2^32.

## Operation
- States: IDLE, FILL, ARMED, POST, DRAIN.
- Config latching: `cfg_*` are latched on the accepted arm. Q is saturated to N-1-P when P+Q > N-1. Window length L = P+1+Q; the trigger sample is included.
- IDLE: nothing is written. An arm moves to FILL and clears the fill counter, write pointer and previous-sample-valid flag. An arm outside IDLE is ignored.
- FILL: every accepted sample is written at the write pointer, which then increments modulo N. Move to ARMED once P samples have been written since the arm (immediately if P=0). Triggers are not evaluated in FILL.
- ARMED: samples keep being written.
  - Trigger condition with rising edge: prev < thr and cur >= thr.
  - Trigger condition with falling edge: prev >= thr and cur < thr.
  - prev is the last accepted sample, valid from the second accepted sample after the arm. A comparison in FILL still updates prev.
  - On a trigger: record trigger address T, write the trigger sample, increment `sts_trig_count`, then go to POST, or to DRAIN directly if Q=0.
- POST: write Q more accepted samples, then go to DRAIN.
- DRAIN: writes are frozen and ADC samples are dropped. Read addresses T-P .. T+Q (mod N) in order, oldest first. `m_axis_tlast` is asserted on beat L only.
- Completion: after the tlast handshake, pulse `sts_done` and go to IDLE.
- Abort: next state is IDLE from any state. `m_axis_tvalid` drops the next cycle with no tlast, which truncates the stream. No `sts_done`.
- Priority: abort > arm. Abort in the same cycle as a trigger leaves `sts_trig_count` unchanged.

## Timing
- Reset values: state IDLE, `m_axis_tvalid`=0, `m_axis_tlast`=0, `m_axis_tdata`=0, `sts_busy`=0, `sts_done`=0, `sts_trig_count`=0, all pointers and counters 0.
- `sts_busy` rises the cycle after an accepted arm.
- Buffer is one synchronous-read RAM with one cycle of read latency.
- First `m_axis_tvalid` comes no later than 2 cycles after entering DRAIN.
- Throughput: with `m_axis_tready` held high, one beat per cycle with no bubbles (prefetch/skid required).
- AXI4-Stream rules:
  - tvalid, once high, stays high with tdata/tlast stable until the handshake; abort is the only exception.
  - tvalid does not depend combinationally on tready.
- `sts_done` is high the cycle after the final handshake, in the same cycle `sts_busy` falls.
- Trigger detection is registered: the trigger sample is the one compared. Its write and T are captured in the same acceptance cycle.

## Configuration
- `ADC_CAPTURE_SWTRIG_EN`:
  - Defined: adds input `ctrl_swtrig` (1 bit, pulse). In ARMED it forces a trigger on the next accepted sample regardless of level. It is ignored in other states.
  - Undefined: the port is absent and only the level trigger exists.

## Test plan
- Reset: assert `ARESETN` low mid-DRAIN -> all outputs at reset values asynchronously, state IDLE after release.
- Rising trigger: DEPTH_LOG2=10, thr=100, P=4, Q=3, ramp 0,10,20,... with tready=1 -> trigger on sample 100. Stream is 60,70,80,90,100,110,120,130, tlast on beat 8, `sts_done` pulse, `sts_trig_count`=1.
- FILL masking: P=8, ramp crosses thr at the 3rd sample -> no trigger. A later crossing after 8 samples triggers with 8 correct pre-samples.
- Saturation and wrap: P=1000, Q=100 -> Q saturated to 23, L=1024. Readout wraps the address correctly and matches the written data.
- Backpressure: random tready at 30% -> data order and tlast unchanged, tdata held stable while tvalid && !tready.
- Abort: `ctrl_abort` after 3 beats of DRAIN -> tvalid=0 next cycle, no tlast, no `sts_done`. A re-arm works normally.
